// File: rtl/ysyx_23060236_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between IFU (m0, bursts) and LSU (m1).
// One read outstanding at a time; beats are counted and rid/rlast mismatches set a sticky flag.
module ysyx_23060236_rd_arbiter #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  // m0 (IFU)
  input  logic [31:0]      m0_araddr,
  input  logic             m0_arvalid,
  output logic             m0_arready,
  input  logic [LEN_W-1:0] m0_arlen,
  input  logic [2:0]       m0_arsize,
  input  logic [1:0]       m0_arburst,
  output logic [31:0]      m0_rdata,
  output logic [1:0]       m0_rresp,
  output logic             m0_rlast,
  output logic             m0_rvalid,
  input  logic             m0_rready,
  // m1 (LSU)
  input  logic [31:0]      m1_araddr,
  input  logic             m1_arvalid,
  output logic             m1_arready,
  input  logic [LEN_W-1:0] m1_arlen,
  input  logic [2:0]       m1_arsize,
  input  logic [1:0]       m1_arburst,
  output logic [31:0]      m1_rdata,
  output logic [1:0]       m1_rresp,
  output logic             m1_rlast,
  output logic             m1_rvalid,
  input  logic             m1_rready,
  // downstream
  output logic [31:0]      s_araddr,
  output logic             s_arvalid,
  output logic [3:0]       s_arid,
  output logic [LEN_W-1:0] s_arlen,
  output logic [2:0]       s_arsize,
  output logic [1:0]       s_arburst,
  input  logic             s_arready,
  input  logic [31:0]      s_rdata,
  input  logic [1:0]       s_rresp,
  input  logic             s_rlast,
  input  logic             s_rvalid,
  input  logic [3:0]       s_rid,
  output logic             s_rready,
  output logic             busy,
  output logic             proto_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic [1:0]       r_state, w_state_d;
  logic             r_gnt, w_gnt_d;
  logic             r_last_gnt, w_last_gnt_d;
  logic [LEN_W-1:0] r_beats, w_beats_d;
  logic             r_proto_err, w_proto_err_d;

  logic w_in_addr, w_in_data, w_sel_m0, w_sel_m1;
  logic w_gnt_arvalid, w_ar_hs, w_beat, w_rid_bad, w_len_bad;

  assign w_in_addr     = (r_state == StAddr);
  assign w_in_data     = (r_state == StData);
  assign w_sel_m0      = w_in_data & ~r_gnt;
  assign w_sel_m1      = w_in_data & r_gnt;
  assign w_gnt_arvalid = r_gnt ? m1_arvalid : m0_arvalid;
  assign w_ar_hs       = w_in_addr & w_gnt_arvalid & s_arready;
  assign w_beat        = w_in_data & s_rvalid & s_rready;
  assign w_rid_bad     = (s_rid != {3'b000, r_gnt});
  // rlast must coincide exactly with the beat counter reaching zero
  assign w_len_bad     = (s_rlast && (r_beats != '0)) || (!s_rlast && (r_beats == '0));

  always_comb begin
    w_state_d     = r_state;
    w_gnt_d       = r_gnt;
    w_last_gnt_d  = r_last_gnt;
    w_beats_d     = r_beats;
    w_proto_err_d = r_proto_err;
    case (r_state)
      StIdle: begin
        if (m0_arvalid | m1_arvalid) begin
          w_state_d = StAddr;
          w_gnt_d   = (m0_arvalid & m1_arvalid) ? ~r_last_gnt : m1_arvalid;
        end
      end
      StAddr: begin
        if (w_ar_hs) begin
          w_state_d = StData;
          w_beats_d = r_gnt ? m1_arlen : m0_arlen;
        end
      end
      StData: begin
        if (w_beat) begin
          if (r_beats != '0) w_beats_d = r_beats - LEN_W'(1);
          if (w_rid_bad || w_len_bad) w_proto_err_d = 1'b1;
          if (s_rlast) begin
            w_state_d    = StIdle;
            w_last_gnt_d = r_gnt;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_gnt       <= 1'b0;
      r_last_gnt  <= 1'b1;
      r_beats     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_gnt       <= w_gnt_d;
      r_last_gnt  <= w_last_gnt_d;
      r_beats     <= w_beats_d;
      r_proto_err <= w_proto_err_d;
    end
  end

  assign s_arvalid  = w_in_addr & w_gnt_arvalid;
  assign s_araddr   = w_in_addr ? (r_gnt ? m1_araddr : m0_araddr) : '0;
  assign s_arlen    = w_in_addr ? (r_gnt ? m1_arlen : m0_arlen) : '0;
  assign s_arsize   = w_in_addr ? (r_gnt ? m1_arsize : m0_arsize) : '0;
  assign s_arburst  = w_in_addr ? (r_gnt ? m1_arburst : m0_arburst) : '0;
  assign s_arid     = w_in_addr ? {3'b000, r_gnt} : '0;
  assign m0_arready = w_in_addr & ~r_gnt & s_arready;
  assign m1_arready = w_in_addr & r_gnt & s_arready;

  assign m0_rvalid = w_sel_m0 & s_rvalid;
  assign m0_rdata  = w_sel_m0 ? s_rdata : '0;
  assign m0_rresp  = w_sel_m0 ? s_rresp : '0;
  assign m0_rlast  = w_sel_m0 & s_rlast;
  assign m1_rvalid = w_sel_m1 & s_rvalid;
  assign m1_rdata  = w_sel_m1 ? s_rdata : '0;
  assign m1_rresp  = w_sel_m1 ? s_rresp : '0;
  assign m1_rlast  = w_sel_m1 & s_rlast;
  assign s_rready  = w_in_data & (r_gnt ? m1_rready : m0_rready);

  assign busy      = (r_state != StIdle);
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
// Bench for ysyx_23060236_rd_arbiter: vector table, directed corner sequences and a
// randomized run checked against a transaction-level arbitration model.
module tb_ysyx_23060236_rd_arbiter;
  localparam int unsigned LEN_W = 8;

  logic clock = 1'b0;
  logic reset;
  logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata, s_araddr, s_rdata;
  logic m0_arvalid, m0_arready, m0_rlast, m0_rvalid, m0_rready;
  logic m1_arvalid, m1_arready, m1_rlast, m1_rvalid, m1_rready;
  logic [LEN_W-1:0] m0_arlen, m1_arlen, s_arlen;
  logic [2:0] m0_arsize, m1_arsize, s_arsize;
  logic [1:0] m0_arburst, m1_arburst, s_arburst, m0_rresp, m1_rresp, s_rresp;
  logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, busy, proto_err;
  logic [3:0] s_arid, s_rid;

  ysyx_23060236_rd_arbiter #(.LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rid(s_rid), .s_rready(s_rready), .busy(busy), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m0_araddr = '0; m0_arvalid = 0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = 2'd1;
    m1_araddr = '0; m1_arvalid = 0; m1_arlen = '0; m1_arsize = 3'd2; m1_arburst = 2'd0;
    m0_rready = 1; m1_rready = 1; s_arready = 0;
    s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rvalid = 0; s_rid = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  // From IDLE: issue an m0 read; returns in the first DATA cycle.
  task automatic m0_req(input logic [31:0] addr, input logic [7:0] len);
    m0_arvalid = 1; m0_araddr = addr; m0_arlen = len; s_arready = 1;
    tick();
    #1;
    chk("m0req_s_arvalid", 32'(s_arvalid), 32'd1);
    chk("m0req_s_arlen", 32'(s_arlen), 32'(len));
    chk("m0req_s_arid", 32'(s_arid), 32'd0);
    tick();
    m0_arvalid = 0; s_arready = 0;
  endtask

  function automatic logic [31:0] fdat(input logic [31:0] a, input int b);
    return a ^ (32'(b) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  typedef struct {
    logic        m1_arvalid, s_arready, s_rvalid, s_rlast;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic        e_busy, e_s_arvalid;
    logic [3:0]  e_s_arid;
    logic [31:0] e_s_araddr;
    logic [7:0]  e_s_arlen;
    logic        e_m1_arready, e_m1_rvalid;
    logic [31:0] e_m1_rdata;
    logic        e_proto_err;
  } vec_t;

  vec_t vecs[7];

  // randomized-phase model state
  bit          req_act[2];
  int          req_start[2];
  logic [31:0] req_addr[2];
  logic [7:0]  req_len[2];
  bit          sl_act, sl_pres, sl_id;
  logic [31:0] sl_addr;
  int          sl_len, sl_beat;
  int          last_end, n_done, d, mn;
  bit          last_served, hs0, hs1, sh, g, both;
  bit          rr_exp[3];
  bit          gaps[8];
  int          cnt;

  initial begin
    reset = 1;
    clear_inputs();
    do_reset();

    // single m1 read, cycle by cycle
    vecs[0] = '{0, 0, 0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0, 8'd0, 0, 0, 32'h0, 0};
    vecs[1] = '{1, 0, 0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0, 8'd0, 0, 0, 32'h0, 0};
    vecs[2] = '{1, 0, 0, 0, 4'd0, 32'h0, 1, 1, 4'd1, 32'h8000_0000, 8'd0, 0, 0, 32'h0, 0};
    vecs[3] = '{1, 1, 0, 0, 4'd0, 32'h0, 1, 1, 4'd1, 32'h8000_0000, 8'd0, 1, 0, 32'h0, 0};
    vecs[4] = '{0, 0, 0, 0, 4'd1, 32'hDEAD_BEEF, 1, 0, 4'd0, 32'h0, 8'd0, 0, 0,
                32'hDEAD_BEEF, 0};
    vecs[5] = '{0, 0, 1, 1, 4'd1, 32'h1234_5678, 1, 0, 4'd0, 32'h0, 8'd0, 0, 1,
                32'h1234_5678, 0};
    vecs[6] = '{0, 0, 0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0, 8'd0, 0, 0, 32'h0, 0};
    m1_araddr = 32'h8000_0000;
    for (int i = 0; i < 7; i++) begin
      m1_arvalid = vecs[i].m1_arvalid; s_arready = vecs[i].s_arready;
      s_rvalid = vecs[i].s_rvalid; s_rlast = vecs[i].s_rlast;
      s_rid = vecs[i].s_rid; s_rdata = vecs[i].s_rdata;
      #1;
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_s_arvalid", i), 32'(s_arvalid), 32'(vecs[i].e_s_arvalid));
      chk($sformatf("vec%0d_s_arid", i), 32'(s_arid), 32'(vecs[i].e_s_arid));
      chk($sformatf("vec%0d_s_araddr", i), s_araddr, vecs[i].e_s_araddr);
      chk($sformatf("vec%0d_s_arlen", i), 32'(s_arlen), 32'(vecs[i].e_s_arlen));
      chk($sformatf("vec%0d_m1_arready", i), 32'(m1_arready), 32'(vecs[i].e_m1_arready));
      chk($sformatf("vec%0d_m1_rvalid", i), 32'(m1_rvalid), 32'(vecs[i].e_m1_rvalid));
      chk($sformatf("vec%0d_m1_rdata", i), m1_rdata, vecs[i].e_m1_rdata);
      chk($sformatf("vec%0d_m0_rvalid", i), 32'(m0_rvalid), 32'd0);
      chk($sformatf("vec%0d_proto_err", i), 32'(proto_err), 32'(vecs[i].e_proto_err));
      tick();
    end

    // m0 4-beat burst with rvalid gaps
    do_reset();
    m0_req(32'h0000_1000, 8'd3);
    gaps = '{0, 1, 0, 1, 1, 0, 0, 1};
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      s_rvalid = gaps[i]; s_rdata = 32'hB000 + 32'(i); s_rid = 4'd0;
      s_rlast = gaps[i] && (cnt == 3);
      #1;
      chk("burst_rvalid", 32'(m0_rvalid), 32'(gaps[i]));
      if (gaps[i]) begin
        chk("burst_rdata", m0_rdata, 32'hB000 + 32'(i));
        chk("burst_rlast", 32'(m0_rlast), 32'(cnt == 3));
        cnt++;
      end
      if (m0_rvalid && m0_rready) cnt += 0;
      tick();
    end
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("burst_idle_after", 32'(busy), 32'd0);
    chk("burst_proto_err", 32'(proto_err), 32'd0);
    tick();

    // simultaneous contention three times: m0, m1, m0
    do_reset();
    rr_exp = '{0, 1, 0};
    m0_arvalid = 1; m1_arvalid = 1; m0_araddr = 32'h100; m1_araddr = 32'h200;
    s_arready = 1;
    for (int k = 0; k < 3; k++) begin
      s_rvalid = 0; s_rlast = 0;
      #1;
      chk("rr_idle_busy", 32'(busy), 32'd0);
      chk("rr_idle_arvalid", 32'(s_arvalid), 32'd0);
      tick();
      chk("rr_grant_id", 32'(s_arid), 32'(rr_exp[k]));
      chk("rr_arready", {30'd0, m1_arready, m0_arready}, rr_exp[k] ? 32'd2 : 32'd1);
      tick();
      s_rvalid = 1; s_rlast = 1; s_rid = {3'b000, rr_exp[k]}; s_rdata = 32'(k);
      #1;
      chk("rr_rvalid", {30'd0, m1_rvalid, m0_rvalid}, rr_exp[k] ? 32'd2 : 32'd1);
      chk("rr_held_off", {30'd0, m1_arready, m0_arready}, 32'd0);
      tick();
    end
    s_rvalid = 0; s_rlast = 0; m0_arvalid = 0; m1_arvalid = 0;
    #1;
    chk("rr_proto_err", 32'(proto_err), 32'd0);
    tick();

    // early rlast, then wrong rid
    do_reset();
    m0_req(32'h0000_2000, 8'd3);
    s_rvalid = 1; s_rlast = 0; s_rid = 4'd0;
    #1;
    chk("early_rlast_beat1", 32'(proto_err), 32'd0);
    tick();
    s_rlast = 1;
    tick();
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("early_rlast_err", 32'(proto_err), 32'd1);
    chk("early_rlast_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("early_rlast_sticky", 32'(proto_err), 32'd1);
    do_reset();
    #1;
    chk("proto_err_reset", 32'(proto_err), 32'd0);
    m0_req(32'h0000_3000, 8'd0);
    s_rvalid = 1; s_rlast = 1; s_rid = 4'd1;
    tick();
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("bad_rid_err", 32'(proto_err), 32'd1);

    // reset during beat 2 of a burst
    do_reset();
    m0_req(32'h0000_4000, 8'd3);
    s_rvalid = 1; s_rlast = 0; s_rid = 4'd0;
    tick();
    #1;
    chk("rst_mid_pre_rvalid", 32'(m0_rvalid), 32'd1);
    reset = 1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_s_rready", 32'(s_rready), 32'd0);
    chk("rst_mid_m0_rvalid", 32'(m0_rvalid), 32'd0);
    tick();
    reset = 0; s_rvalid = 0;
    tick();
    m0_req(32'h0000_5000, 8'd0);
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'hCAFE_F00D; s_rid = 4'd0;
    #1;
    chk("rst_after_rdata", m0_rdata, 32'hCAFE_F00D);
    chk("rst_after_rlast", 32'(m0_rlast), 32'd1);
    tick();
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("rst_after_idle", 32'(busy), 32'd0);
    chk("rst_after_proto", 32'(proto_err), 32'd0);

    // randomized traffic against the arbitration model
    do_reset();
    req_act = '{0, 0};
    sl_act = 0; sl_pres = 0; sl_id = 0; sl_addr = '0; sl_len = 0; sl_beat = 0;
    last_end = -1; last_served = 1; n_done = 0;
    for (int t = 0; t < 4000; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_act[p] && $urandom_range(0, 3) == 0) begin
          req_act[p] = 1; req_start[p] = t;
          req_addr[p] = $urandom & 32'hFFFF_FFFC;
          req_len[p] = (p == 0) ? 8'($urandom_range(0, 3)) : 8'd0;
        end
      end
      m0_arvalid = req_act[0]; m0_araddr = req_addr[0]; m0_arlen = req_len[0];
      m1_arvalid = req_act[1]; m1_araddr = req_addr[1]; m1_arlen = req_len[1];
      m0_rready = ($urandom_range(0, 3) != 0);
      m1_rready = ($urandom_range(0, 3) != 0);
      s_arready = ($urandom_range(0, 1) != 0);
      if (sl_act) begin
        if (!sl_pres) sl_pres = ($urandom_range(0, 2) != 0);
      end else begin
        sl_pres = 0;
      end
      s_rvalid = sl_pres;
      s_rdata = sl_pres ? fdat(sl_addr, sl_beat) : 32'h0;
      s_rlast = sl_pres && (sl_beat == sl_len);
      s_rid = {3'b000, sl_id};
      #1;
      if (sl_act && sl_pres) begin
        chk("rnd_s_rready", 32'(s_rready), sl_id ? 32'(m1_rready) : 32'(m0_rready));
        chk("rnd_rvalid", {30'd0, m1_rvalid, m0_rvalid}, sl_id ? 32'd2 : 32'd1);
        chk("rnd_rdata", sl_id ? m1_rdata : m0_rdata, fdat(sl_addr, sl_beat));
        chk("rnd_rlast", sl_id ? 32'(m1_rlast) : 32'(m0_rlast), 32'(sl_beat == sl_len));
        if (s_rready) begin
          sl_pres = 0;
          if (sl_beat == sl_len) begin
            sl_act = 0; last_served = sl_id; last_end = t; n_done++;
          end else begin
            sl_beat++;
          end
        end
      end else begin
        hs0 = m0_arvalid & m0_arready;
        hs1 = m1_arvalid & m1_arready;
        sh = s_arvalid & s_arready;
        if (hs0 || hs1 || sh) begin
          // grant decided in the first IDLE cycle that saw a request
          mn = t;
          for (int p = 0; p < 2; p++) if (req_act[p] && req_start[p] < mn) mn = req_start[p];
          d = (last_end + 1 > mn) ? last_end + 1 : mn;
          both = req_act[0] && req_start[0] <= d && req_act[1] && req_start[1] <= d;
          g = both ? ~last_served : (req_act[1] && req_start[1] <= d);
          chk("rnd_ar_port", {30'd0, hs1, hs0}, g ? 32'd2 : 32'd1);
          chk("rnd_ar_handshake", 32'(sh), 32'd1);
          chk("rnd_arid", 32'(s_arid), 32'(g));
          chk("rnd_araddr", s_araddr, req_addr[g]);
          chk("rnd_arlen", 32'(s_arlen), 32'(req_len[g]));
          req_act[g] = 0;
          sl_act = 1; sl_id = g; sl_addr = req_addr[g]; sl_len = int'(req_len[g]);
          sl_beat = 0;
        end
      end
      chk("rnd_proto_err", 32'(proto_err), 32'd0);
      tick();
    end
    chk("rnd_progress", 32'(n_done >= 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060236_rd_arbiter.md
# ysyx_23060236_rd_arbiter

Round-robin arbiter that shares one AXI4 read channel between two requesters: port m0 (IFU, bursts) and port m1 (LSU, single beats). It sits between the core's fetch/load units and the SoC `io_master` read channel. It serialises transactions with one outstanding read at a time and tracks burst beats. It checks response ID and `rlast` consistency and raises a sticky protocol-error flag.

## Interface
- `LEN_W`, default 8: width of `arlen` fields and of the beat counter.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_araddr`  in  32  m0 read address.
- `m0_arvalid`  in  1  m0 address valid.
- `m0_arready`  out  1  m0 address accepted.
- `m0_arlen`  in  LEN_W  m0 burst length minus one.
- `m0_arsize`  in  3  m0 beat size.
- `m0_arburst`  in  2  m0 burst type.
- `m0_rdata` / `m0_rresp` / `m0_rlast` / `m0_rvalid`  out  32 / 2 / 1 / 1  m0 read data channel.
- `m0_rready`  in  1  m0 accepts data.
- `m1_*`: the same set as m0. The LSU instance ties `m1_arlen` to 0 and `m1_arburst` to 0.
- `s_araddr` / `s_arvalid` / `s_arid` / `s_arlen` / `s_arsize` / `s_arburst`  out  32 / 1 / 4 / LEN_W / 3 / 2  downstream AR channel.
- `s_arready`  in  1  downstream address accepted.
- `s_rdata` / `s_rresp` / `s_rlast` / `s_rvalid` / `s_rid`  in  32 / 2 / 1 / 1 / 4  downstream R channel.
- `s_rready`  out  1  arbiter accepts downstream data.
- `busy`  out  1  state is not IDLE.
- `proto_err`  out  1  sticky protocol-error flag.

## Operation
- State machine with three states.
  - IDLE: no grant.
  - ADDR: granted requester's AR fields are forwarded.
  - DATA: downstream R channel is routed to the granted requester.
- Registers:
  - `state`
  - `gnt`: 0 = m0, 1 = m1.
  - `last_gnt`: the port served most recently.
  - `beats`: LEN_W bits.
  - `proto_err`
- IDLE → ADDR when `m0_arvalid | m1_arvalid`.
  - Only one valid: grant that port.
  - Both valid: grant `~last_gnt`.
- ADDR behaviour:
  - `s_arvalid` equals the granted port's `arvalid`.
  - Address, len, size and burst come from the granted port.
  - `s_arid` = {3'b0, gnt}.
  - Granted port's `arready` = `s_arready`.
  - Non-granted `arready` = 0.
- ADDR → DATA on `s_arvalid & s_arready`; load `beats` ← granted `arlen`.
- DATA behaviour:
  - Granted port's `rvalid`, `rdata`, `rresp` and `rlast` equal the downstream values.
  - `s_rready` = granted port's `rready`.
  - Non-granted port: `rvalid` = 0, and `rdata`, `rresp` and `rlast` = 0.
- On each beat (`s_rvalid & s_rready`):
  - If `beats != 0`, decrement `beats`.
  - If `s_rlast`, go to IDLE and set `last_gnt` ← `gnt`.
- `proto_err` is set, and stays set until reset, on any of these beat conditions:
  - `s_rid != {3'b0, gnt}`;
  - `s_rlast` with `beats != 0`;
  - `beats == 0` without `s_rlast`.
- The transaction ends only on `s_rlast`. A missing `rlast` keeps the arbiter in DATA.
- In IDLE all `arready`, `rvalid` and `s_arvalid` outputs are 0, as is `s_rready`. `s_araddr` and the other AR fields are 0.
- Arithmetic: `beats` is unsigned LEN_W bits and never wraps below 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, `last_gnt` = 1 (so m0 wins the first contention), `beats` = 0.
  - `proto_err` = 0, `busy` = 0.
  - All valid and ready outputs are 0; all data outputs are 0.
- Grant latency: request in IDLE at cycle N → `s_arvalid` high in cycle N+1.
- AR and R forwarding is combinational within ADDR and DATA; no added latency per beat.
- The cycle after the last beat is always IDLE, so there is at least one dead cycle between transactions.
- A requester's `arvalid` must stay high until `arready` (AXI rule). If it drops in ADDR, the arbiter stays in ADDR with `s_arvalid` = 0.
- A request from the non-granted port during ADDR or DATA is held off (`arready` = 0). It is granted in the IDLE cycle after the current transaction.
- Reset asserted mid-burst returns to IDLE immediately. The downstream slave must be reset by the same signal.

## Test plan
- Single m1 read at 0x8000_0000, slave returns 0x1234_5678 with `rlast`:
  - `s_arvalid` rises 1 cycle after the request, with `s_arid` = 1 and `s_arlen` = 0.
  - `m1_rdata` = 0x1234_5678; `proto_err` = 0.
- m0 4-beat burst (`arlen` = 3), slave inserts `rvalid` gaps: m0 receives exactly 4 beats, `rlast` on the 4th, then state returns to IDLE.
- m0 and m1 assert `arvalid` in the same cycle, three times back-to-back:
  - Grants are m0, m1, m0.
  - No grant is issued while `busy` = 1.
- Slave asserts `rlast` on beat 2 of an `arlen` = 3 burst → `proto_err` = 1 and stays 1. Slave returns `rid` = 1 for an m0 grant → `proto_err` = 1.
- Assert `reset` during beat 2 of a burst:
  - `busy`, `s_rready` and `m0_rvalid` are 0 in the same cycle.
  - After reset releases, a new m0 request completes normally.
